// File: rtl/cla_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial CLA adder.
// Imported by the top and by the slice.
package cla_serial_adder_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

// File: rtl/cla_serial_adder_cla4.sv
// Shared 4-bit carry-lookahead slice.
// Reports nibble sum plus group generate/propagate.
import cla_serial_adder_pkg::*;

module cla_4bits (
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_c,
   output logic [SLICE_W-1:0] o_s,
   output logic               o_gm,
   output logic               o_pm
);

   logic [SLICE_W-1:0] w_g;
   logic [SLICE_W-1:0] w_p;
   logic [SLICE_W-1:0] w_c;

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   assign w_c[0] = i_c;
   assign w_c[1] = w_g[0] | (w_p[0] & i_c);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0])
                 | (w_p[1] & w_p[0] & i_c);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1])
                 | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & i_c);

   assign o_s  = w_p ^ w_c;
   assign o_gm = w_g[3] | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
   assign o_pm = &w_p;

endmodule

// File: rtl/cla_serial_adder.sv
// Nibble-serial adder: one CLA slice reused LSB-first,
// valid/ready on both sides, all outputs registered.
import cla_serial_adder_pkg::*;

module cla_serial_adder #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int CW     = $clog2(NSLICE);
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH-1:0]   r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_ovf;
   logic               r_out_valid;
   logic               r_in_ready;

   logic [SLICE_W-1:0] w_a_nib;
   logic [SLICE_W-1:0] w_b_nib;
   logic [SLICE_W-1:0] w_s;
   logic               w_gm;
   logic               w_pm;
   logic               w_carry_nxt;
   logic               w_ovf;

   assign w_a_nib     = r_a[r_cnt*SLICE_W +: SLICE_W];
   assign w_b_nib     = r_b[r_cnt*SLICE_W +: SLICE_W];
   assign w_carry_nxt = w_gm | (w_pm & r_carry);
   // Only meaningful on the last slice, where w_s holds the MSB nibble
   assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1])
               && (w_s[SLICE_W-1] != r_a[WIDTH-1]);

   cla_4bits u_slice (
      .i_a  (w_a_nib),
      .i_b  (w_b_nib),
      .i_c  (r_carry),
      .o_s  (w_s),
      .o_gm (w_gm),
      .o_pm (w_pm)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_a        <= a;
                  r_b        <= b;
                  r_carry    <= cin;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_sum[r_cnt*SLICE_W +: SLICE_W] <= w_s;
               r_carry <= w_carry_nxt;
               r_cnt   <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_cout      <= w_carry_nxt;
                  r_ovf       <= w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_serial_adder.sv
// Self-checking bench for cla_serial_adder (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_cla_serial_adder;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cla_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   // Unsigned sum gives sum/cout, signed sum gives overflow
   function automatic void ref_add(
      input  logic [31:0] x, y,
      input  logic        c,
      output logic [31:0] s,
      output logic        co,
      output logic        ov
   );
      longint unsigned u;
      longint          sg;
      u  = {32'b0, x} + {32'b0, y} + {63'b0, c};
      s  = u[31:0];
      co = u[32];
      sg = longint'($signed(x)) + longint'($signed(y))
         + longint'({63'b0, c});
      ov = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
   endfunction

   // Drives one request, returns the result and the cycle index
   // (handshake cycle = 0) at which out_valid was first seen.
   task automatic run_op(
      input  logic [31:0] ta, tbv,
      input  logic        tc,
      input  bit          rnd_ready,
      output logic [31:0] rs,
      output logic        rc, ro,
      output int          lat,
      output bit          tmo
   );
      int n;
      bit hs;
      tmo = 1'b0;
      n   = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) tmo = 1'b1;
      a = ta; b = tbv; cin = tc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a   = $urandom;
      b   = $urandom;
      cin = 1'($urandom);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) tmo = 1'b1;
      rs = sum; rc = cout; ro = ovf;
      n = 0;
      do begin
         out_ready = rnd_ready ? 1'($urandom) : 1'b1;
         hs = out_valid && out_ready;
         @(negedge clk);
         n++;
      end while (!hs && n < 50);
      if (!hs) tmo = 1'b1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '1; b = '1; cin = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_checks += 5;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      if (sum !== '0) begin
         n_fail++;
         $display("FAIL reset_sum: got %h want 0", sum);
      end
      if (cout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_cout: got %b want 0", cout);
      end
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: got %b want 0", ovf);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [31:0] va [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
      logic [31:0] vb [3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0001};
      logic        vc [3] = '{1'b0, 1'b1, 1'b0};
      logic [31:0] es [3] = '{32'h0000_0003, 32'h0000_0000, 32'h8000_0000};
      logic        ec [3] = '{1'b0, 1'b1, 1'b0};
      logic        eo [3] = '{1'b0, 1'b0, 1'b1};
      logic [31:0] rs;
      logic        rc, ro;
      int          lat;
      bit          tmo;
      for (int i = 0; i < 3; i++) begin
         run_op(va[i], vb[i], vc[i], 1'b0, rs, rc, ro, lat, tmo);
         n_checks += 5;
         if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_timeout: handshake timed out", i);
         end
         if (rs !== es[i]) begin
            n_fail++;
            $display("FAIL dir%0d_sum: got %h want %h", i, rs, es[i]);
         end
         if (rc !== ec[i]) begin
            n_fail++;
            $display("FAIL dir%0d_cout: got %b want %b", i, rc, ec[i]);
         end
         if (ro !== eo[i]) begin
            n_fail++;
            $display("FAIL dir%0d_ovf: got %b want %b", i, ro, eo[i]);
         end
         if (lat !== 9) begin
            n_fail++;
            $display("FAIL dir%0d_latency: got %0d want 9", i, lat);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] xa, xb, es;
      logic        xc, ec, eo;
      int          n;
      xa = $urandom; xb = $urandom; xc = 1'($urandom);
      ref_add(xa, xb, xc, es, ec, eo);
      out_ready = 1'b0;
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_reach_done: got %b want 1", out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks += 5;
         if (sum !== es) begin
            n_fail++;
            $display("FAIL bp_sum_c%0d: got %h want %h", i, sum, es);
         end
         if (cout !== ec) begin
            n_fail++;
            $display("FAIL bp_cout_c%0d: got %b want %b", i, cout, ec);
         end
         if (ovf !== eo) begin
            n_fail++;
            $display("FAIL bp_ovf_c%0d: got %b want %b", i, ovf, eo);
         end
         if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_valid_c%0d: got %b want 1", i, out_valid);
         end
         if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready_c%0d: got %b want 0", i, in_ready);
         end
         a = $urandom; b = $urandom; in_valid = 1'($urandom);
         @(negedge clk);
      end
      // new request coincides with the accepting edge
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      n_checks += 2;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: out_valid got %b want 0", out_valid);
      end
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_no_same_cycle_start: in_ready got %b want 1",
                  in_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_once_c%0d: out_valid got %b want 0",
                     i, out_valid);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] rs;
      logic        rc, ro;
      int          lat;
      bit          tmo;
      a = $urandom; b = $urandom; cin = 1'b1; in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks += 3;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_run_valid: got %b want 0", out_valid);
      end
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_run_in_ready: got %b want 1", in_ready);
      end
      if (sum !== '0) begin
         n_fail++;
         $display("FAIL rst_run_sum: got %h want 0", sum);
      end
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_stale_c%0d: out_valid got %b want 0",
                     i, out_valid);
         end
      end
      run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0,
             rs, rc, ro, lat, tmo);
      n_checks += 4;
      if (tmo !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after_timeout: handshake timed out");
      end
      if (rs !== 32'h2345_6789) begin
         n_fail++;
         $display("FAIL rst_after_sum: got %h want 23456789", rs);
      end
      if (rc !== 1'b0 || ro !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_after_flags: got c=%b o=%b want 0 0", rc, ro);
      end
      if (lat !== 9) begin
         n_fail++;
         $display("FAIL rst_after_latency: got %0d want 9", lat);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xa, xb, rs, es;
      logic        xc, rc, ro, ec, eo;
      int          lat;
      bit          tmo;
      for (int i = 0; i < 1000; i++) begin
         xa = $urandom; xb = $urandom; xc = 1'($urandom);
         case (i % 8)
            1: xa = 32'hFFFF_FFFF;
            2: xb = 32'h8000_0000;
            default: ;
         endcase
         ref_add(xa, xb, xc, es, ec, eo);
         run_op(xa, xb, xc, 1'b1, rs, rc, ro, lat, tmo);
         n_checks += 5;
         if (tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd%0d_timeout: handshake timed out", i);
         end
         if (rs !== es) begin
            n_fail++;
            $display("FAIL rnd%0d_sum: %h+%h+%b got %h want %h",
                     i, xa, xb, xc, rs, es);
         end
         if (rc !== ec) begin
            n_fail++;
            $display("FAIL rnd%0d_cout: got %b want %b", i, rc, ec);
         end
         if (ro !== eo) begin
            n_fail++;
            $display("FAIL rnd%0d_ovf: got %b want %b", i, ro, eo);
         end
         if (lat !== 9) begin
            n_fail++;
            $display("FAIL rnd%0d_latency: got %0d want 9", i, lat);
         end
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cla_serial_adder.md
CLA_SERIAL_ADDER -- requirements
Module: cla_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: request carries valid operands.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port a, input, WIDTH bits: addend A.
REQ-007 SHALL have port b, input, WIDTH bits: addend B.
REQ-008 SHALL have port cin, input, 1 bit: carry-in.
REQ-009 SHALL have port out_valid, output, 1 bit: result fields are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port sum, output, WIDTH bits: (a+b+cin) mod 2^WIDTH.
REQ-012 SHALL have port cout, output, 1 bit: carry-out of the MSB.
REQ-013 SHALL have port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-014 SHALL compute the sum with one shared 4-bit CLA slice, reused over NSLICE = WIDTH/4 consecutive cycles, processing the least significant nibble first.
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 IDLE SHALL drive in_ready=1; on in_valid&&in_ready it SHALL capture a, b and cin into operand and carry registers, clear the slice counter, and go to RUN.
REQ-017 RUN SHALL present nibble k of the captured operands and the carry register to the slice in each cycle k = 0..NSLICE-1.
REQ-018 In each RUN cycle it SHALL write the slice sum to sum[4k+3:4k] and load the carry register with gm | (pm & carry).
REQ-019 After cycle k = NSLICE-1 the FSM SHALL enter DONE.
REQ-020 DONE SHALL assert out_valid=1 and hold sum, cout and ovf stable until out_valid&&out_ready, then return to IDLE.
REQ-021 Latency SHALL be NSLICE+1 cycles from the accepting edge to the first out_valid cycle (9 for WIDTH=32); throughput SHALL be at most one result per NSLICE+2 cycles.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, and the captured operands SHALL be immune to input changes.
REQ-023 cout SHALL equal the final carry register value; ovf SHALL be (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]), evaluated on the captured operands.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 Wrap-around: a result of 2^WIDTH or more SHALL yield a truncated sum with cout=1.
REQ-026 Simultaneous DONE-accept and new in_valid SHALL NOT start the new operation in the same cycle; the new request is accepted in the following IDLE cycle.

Reset
REQ-027 Asserting rst SHALL immediately force state IDLE, counter 0, carry register 0, and sum, cout, ovf and out_valid to 0, with in_ready=1 while in IDLE.
REQ-028 A reset during RUN or DONE SHALL discard the operation with no output produced; the first rising edge after release SHALL behave as IDLE.

Structure
REQ-029 A shared package SHALL hold the FSM state enumeration (IDLE/RUN/DONE) and the slice width constant SLICE_W=4.
REQ-030 SHALL instantiate the existing sub-module cla_4bits exactly once as the shared slice; no other adder logic on the datapath.
REQ-031 The counter width SHALL be $clog2(NSLICE); all outputs SHALL be driven from registers.

Verification
REQ-032 The bench SHALL drive WIDTH=32, a=0x0000_0001, b=0x0000_0002, cin=0 and check sum=0x0000_0003, cout=0, ovf=0, with out_valid first seen 9 cycles after acceptance.
REQ-033 The bench SHALL drive a=0xFFFF_FFFF, b=0x0000_0000, cin=1 and check sum=0x0000_0000, cout=1, ovf=0, confirming the carry ripples through all 8 slices.
REQ-034 The bench SHALL drive a=0x7FFF_FFFF, b=0x0000_0001, cin=0 and check sum=0x8000_0000, cout=0, ovf=1.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE while toggling a, b and in_valid, and check that the outputs stay stable, in_ready=0, and the result is accepted exactly once.
REQ-036 The bench SHALL assert rst at RUN cycle 3, then issue a=0x1234_5678, b=0x1111_1111, and check no stale out_valid appears and the result is sum=0x2345_6789.
REQ-037 The bench SHALL run 1000 back-to-back random requests with random out_ready and compare each result against a+b+cin in a reference model.
